// File: rtl/sigma_delta_decimator.sv
// Third-order CIC (sinc3) decimator for a unipolar 1-bit sigma-delta stream.
// Integrators run at the input rate, combs at the decimated rate.
module sigma_delta_decimator #(
  parameter int M     = 6,
  parameter int OUT_W = 3*M+1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             DIN,
  input  logic             DIN_EN,
  output logic [OUT_W-1:0] DOUT,
  output logic             DOUT_VALID,
  output logic [M-1:0]     PHASE
);

  logic [OUT_W-1:0] i1_q, i1_d;
  logic [OUT_W-1:0] i2_q, i2_d;
  logic [OUT_W-1:0] i3_q, i3_d;
  logic [OUT_W-1:0] t_q, t_d;
  logic             tap_q, tap_d;
  logic [OUT_W-1:0] c1d_q, c1d_d;
  logic [OUT_W-1:0] c2d_q, c2d_d;
  logic [OUT_W-1:0] c3d_q, c3d_d;
  logic [OUT_W-1:0] y3_q, y3_d;
  logic             yv_q, yv_d;
  logic [2:0]       fill_q, fill_d;
  logic [M-1:0]     phase_q, phase_d;
  logic [OUT_W-1:0] dout_q, dout_d;
  logic             dv_q, dv_d;

  logic [OUT_W-1:0] y1, y2, y3;
  logic [OUT_W-1:0] din_w;

  always_comb begin
    din_w   = {{(OUT_W-1){1'b0}}, DIN};
    i1_d    = i1_q;
    i2_d    = i2_q;
    i3_d    = i3_q;
    phase_d = phase_q;
    t_d     = t_q;
    tap_d   = 1'b0;
    if (DIN_EN) begin
      i1_d    = i1_q + din_w;
      i2_d    = i2_q + i1_q;
      i3_d    = i3_q + i2_q;
      phase_d = phase_q + 1'b1;
      if (phase_q == {M{1'b1}}) begin
        tap_d = 1'b1;
        t_d   = i3_q + i2_q;
      end
    end
  end

  // Combs run modulo 2^OUT_W so integrator wrap cancels out.
  always_comb begin
    y1     = t_q - c1d_q;
    y2     = y1 - c2d_q;
    y3     = y2 - c3d_q;
    c1d_d  = c1d_q;
    c2d_d  = c2d_q;
    c3d_d  = c3d_q;
    fill_d = fill_q;
    y3_d   = y3_q;
    yv_d   = 1'b0;
    if (tap_q) begin
      c1d_d = t_q;
      c2d_d = y1;
      c3d_d = y2;
      y3_d  = y3;
      yv_d  = (fill_q == 3'd4);
      if (fill_q != 3'd4) fill_d = fill_q + 3'd1;
    end
  end

  always_comb begin
    dout_d = yv_q ? y3_q : dout_q;
    dv_d   = yv_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      i1_q    <= '0;
      i2_q    <= '0;
      i3_q    <= '0;
      t_q     <= '0;
      tap_q   <= 1'b0;
      c1d_q   <= '0;
      c2d_q   <= '0;
      c3d_q   <= '0;
      y3_q    <= '0;
      yv_q    <= 1'b0;
      fill_q  <= 3'd0;
      phase_q <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
    end else begin
      i1_q    <= i1_d;
      i2_q    <= i2_d;
      i3_q    <= i3_d;
      t_q     <= t_d;
      tap_q   <= tap_d;
      c1d_q   <= c1d_d;
      c2d_q   <= c2d_d;
      c3d_q   <= c3d_d;
      y3_q    <= y3_d;
      yv_q    <= yv_d;
      fill_q  <= fill_d;
      phase_q <= phase_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
    end
  end

  assign DOUT       = dout_q;
  assign DOUT_VALID = dv_q;
  assign PHASE      = phase_q;

endmodule

// File: tb/tb_sigma_delta_decimator.sv
// Directed bench for sigma_delta_decimator (M=6, R=64, gain 2^18).
// Periodic patterns must decimate to ones-per-64 times 4096.
module tb_sigma_delta_decimator;

  localparam int M = 6;
  localparam int OW = 3*M+1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          din = 1'b0;
  logic          din_en = 1'b0;
  logic [OW-1:0] dout;
  logic          dout_valid;
  logic [M-1:0]  phase;

  int nchk = 0;
  int nerr = 0;

  logic [7:0] pat = 8'h01;
  int plen = 1;
  int pidx = 0;
  bit gap = 0;
  bit last_en = 0;

  int strobes;
  int mism;
  logic [31:0] last_dout;
  logic [31:0] p0;

  sigma_delta_decimator #(.M(M)) dut (
    .CLK(clk),
    .RST(rst),
    .DIN(din),
    .DIN_EN(din_en),
    .DOUT(dout),
    .DOUT_VALID(dout_valid),
    .PHASE(phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit e);
    din_en = e;
    din = pat[pidx];
    @(posedge clk);
    #1;
    if (e && !rst) pidx = (pidx + 1) % plen;
    last_en = e;
  endtask

  task automatic run(input int n, input int exp);
    strobes = 0;
    mism = 0;
    for (int k = 0; k < n; k++) begin
      cyc(gap ? !last_en : 1'b1);
      if (dout_valid) begin
        strobes++;
        last_dout = 32'(dout);
        if (exp >= 0 && 32'(dout) != 32'(exp)) mism++;
      end
    end
  endtask

  task automatic set_pat(input logic [7:0] p, input int len);
    pat = p;
    plen = len;
    pidx = 0;
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) cyc(1'b0);
    check("reset_dout", 32'(dout), 0);
    check("reset_valid", 32'(dout_valid), 0);
    check("reset_phase", 32'(phase), 0);
    rst = 1'b0;

    set_pat(8'h01, 1);
    run(321, -1);
    check("fill_no_strobe", strobes, 0);
    run(1, -1);
    check("first_strobe_valid", 32'(dout_valid), 1);
    check("first_strobe_dout", 32'(dout), 262144);
    run(1, -1);
    check("strobe_one_cycle", 32'(dout_valid), 0);
    check("dout_holds", 32'(dout), 262144);
    run(63, -1);
    check("second_strobe_valid", 32'(dout_valid), 1);
    check("second_strobe_dout", 32'(dout), 262144);

    set_pat(8'h00, 1);
    run(320, -1);
    run(128, 0);
    check("zeros_strobes", strobes, 2);
    check("zeros_mism", mism, 0);

    set_pat(8'h01, 2);
    run(320, -1);
    run(128, 131072);
    check("alt_strobes", strobes, 2);
    check("alt_mism", mism, 0);

    set_pat(8'h01, 4);
    run(320, -1);
    run(128, 65536);
    check("q1000_strobes", strobes, 2);
    check("q1000_mism", mism, 0);

    set_pat(8'h07, 8);
    run(320, -1);
    run(256, 98304);
    check("d3of8_strobes", strobes, 4);
    check("d3of8_mism", mism, 0);

    set_pat(8'h01, 1);
    gap = 1;
    run(640, -1);
    run(256, 262144);
    check("gap_strobes", strobes, 2);
    check("gap_mism", mism, 0);
    gap = 0;
    p0 = 32'(phase);
    cyc(1'b0);
    check("gap_phase_hold", 32'(phase), p0);

    run(12800, 262144);
    check("long_strobes", strobes, 200);
    check("long_mism", mism, 0);

    rst = 1'b1;
    cyc(1'b1);
    rst = 1'b0;
    run(414, -1);
    check("mid_phase30", 32'(phase), 30);
    check("mid_dout_pre", 32'(dout), 262144);
    rst = 1'b1;
    cyc(1'b1);
    rst = 1'b0;
    check("mid_rst_dout", 32'(dout), 0);
    check("mid_rst_valid", 32'(dout_valid), 0);
    check("mid_rst_phase", 32'(phase), 0);
    run(321, -1);
    check("refill_no_strobe", strobes, 0);
    run(1, -1);
    check("refill_valid", 32'(dout_valid), 1);
    check("refill_dout", 32'(dout), 262144);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
